// File: rtl/johnson_decoder_checker.sv
// Decodes a 4-bit Johnson code to a phase index, checks that successive
// samples follow the ring order, and tracks lock and error statistics.
module johnson_decoder_checker #(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 2,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             async_reset_n,
  input  logic             enable,
  input  logic [3:0]       code_in,
  output logic [2:0]       phase,
  output logic             valid,
  output logic             locked,
  output logic             err_illegal,
  output logic             err_seq,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  localparam logic [3:0]       LOCK_V  = 4'(LOCK_CNT);
  localparam logic [3:0]       LOSS_V  = 4'(LOSS_CNT);
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  // Returns {legal, phase}; illegal codes map to {0, 0}.
  function automatic logic [3:0] decode_code(input logic [3:0] code);
    logic [3:0] res;
    case (code)
      4'b0000: res = 4'b1_000;
      4'b0001: res = 4'b1_001;
      4'b0011: res = 4'b1_010;
      4'b0111: res = 4'b1_011;
      4'b1111: res = 4'b1_100;
      4'b1110: res = 4'b1_101;
      4'b1100: res = 4'b1_110;
      4'b1000: res = 4'b1_111;
      default: res = 4'b0_000;
    endcase
    return res;
  endfunction

  state_t           state_r, state_n;
  logic [3:0]       run_r, run_n;
  logic [3:0]       loss_r, loss_n;
  logic [2:0]       phase_r, phase_n;
  logic             valid_r, valid_n;
  logic             locked_r, locked_n;
  logic             ill_r, ill_n;
  logic             seq_r, seq_n;
  logic [ERR_W-1:0] cnt_r, cnt_n;

  logic [3:0] dec_s;
  logic       legal_s;
  logic [2:0] phase_in_s;
  logic       succ_s;

  assign dec_s      = decode_code(code_in);
  assign legal_s    = dec_s[3];
  assign phase_in_s = dec_s[2:0];
  // Reference is the last legal phase, even if that sample itself erred.
  assign succ_s     = legal_s && (phase_in_s == (phase_r + 3'd1));

  // State and output registers
  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      state_r  <= ST_UNLOCKED;
      run_r    <= 4'd0;
      loss_r   <= 4'd0;
      phase_r  <= 3'd0;
      valid_r  <= 1'b0;
      locked_r <= 1'b0;
      ill_r    <= 1'b0;
      seq_r    <= 1'b0;
      cnt_r    <= {ERR_W{1'b0}};
    end else begin
      state_r  <= state_n;
      run_r    <= run_n;
      loss_r   <= loss_n;
      phase_r  <= phase_n;
      valid_r  <= valid_n;
      locked_r <= locked_n;
      ill_r    <= ill_n;
      seq_r    <= seq_n;
      cnt_r    <= cnt_n;
    end
  end

  // Next-state logic: lock acquisition and loss tracking
  always_comb begin
    state_n = state_r;
    run_n   = run_r;
    loss_n  = loss_r;
    if (enable) begin
      case (state_r)
        ST_UNLOCKED: begin
          if (legal_s) begin
            state_n = ST_ACQUIRE;
            run_n   = 4'd0;
          end else begin
            state_n = ST_UNLOCKED;
          end
        end
        ST_ACQUIRE: begin
          if (!legal_s) begin
            state_n = ST_UNLOCKED;
          end else if (succ_s) begin
            run_n = run_r + 4'd1;
            if ((run_r + 4'd1) == LOCK_V) begin
              state_n = ST_LOCKED;
              loss_n  = 4'd0;
            end else begin
              state_n = ST_ACQUIRE;
            end
          end else begin
            run_n = 4'd0;
          end
        end
        ST_LOCKED: begin
          if (succ_s) begin
            loss_n = 4'd0;
          end else if ((loss_r + 4'd1) == LOSS_V) begin
            state_n = ST_UNLOCKED;
            loss_n  = 4'd0;
          end else begin
            loss_n = loss_r + 4'd1;
          end
        end
        default: begin
          state_n = ST_UNLOCKED;
          run_n   = 4'd0;
          loss_n  = 4'd0;
        end
      endcase
    end else begin
      state_n = state_r;
    end
  end

  // Output logic: phase/valid hold, error pulses and saturating count
  always_comb begin
    phase_n  = phase_r;
    valid_n  = valid_r;
    ill_n    = 1'b0;
    seq_n    = 1'b0;
    cnt_n    = cnt_r;
    locked_n = (state_n == ST_LOCKED);
    if (enable) begin
      if (legal_s) begin
        phase_n = phase_in_s;
        valid_n = 1'b1;
        seq_n   = (state_r == ST_LOCKED) && !succ_s;
      end else begin
        valid_n = 1'b0;
        ill_n   = 1'b1;
      end
      if ((ill_n || seq_n) && (cnt_r != ERR_MAX)) begin
        cnt_n = cnt_r + ERR_W'(1);
      end else begin
        cnt_n = cnt_r;
      end
    end else begin
      locked_n = locked_r;
    end
  end

  assign phase       = phase_r;
  assign valid       = valid_r;
  assign locked      = locked_r;
  assign err_illegal = ill_r;
  assign err_seq     = seq_r;
  assign err_count   = cnt_r;

endmodule

// File: tb/tb_johnson_decoder_checker.sv
// Scoreboard bench: a table-driven ring model predicts every cycle's outputs
// for a default instance and a 2-bit-counter instance sharing the same inputs.
module tb_johnson_decoder_checker;

  logic       clk = 1'b0;
  logic       async_reset_n = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] code_in = 4'd0;

  logic [2:0] phase, s_phase;
  logic       valid, locked, err_illegal, err_seq;
  logic       s_valid, s_locked, s_err_illegal, s_err_seq;
  logic [7:0] err_count;
  logic [1:0] s_err_count;

  johnson_decoder_checker u_dut (
    .clk(clk), .async_reset_n(async_reset_n), .enable(enable), .code_in(code_in),
    .phase(phase), .valid(valid), .locked(locked), .err_illegal(err_illegal),
    .err_seq(err_seq), .err_count(err_count)
  );

  johnson_decoder_checker #(.ERR_W(2)) u_sat (
    .clk(clk), .async_reset_n(async_reset_n), .enable(enable), .code_in(code_in),
    .phase(s_phase), .valid(s_valid), .locked(s_locked), .err_illegal(s_err_illegal),
    .err_seq(s_err_seq), .err_count(s_err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] phase;
    logic       valid;
    logic       locked;
    logic       ill;
    logic       seq;
    logic [7:0] cnt8;
    logic [1:0] cnt2;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int n_pass = 0;
  int n_total = 0;

  // Ring order of the legal codes; index is the phase.
  int jc [8] = '{0, 1, 3, 7, 15, 14, 12, 8};
  int il [8] = '{2, 4, 5, 6, 9, 10, 11, 13};

  // Reference model (mode: 0 hunting, 1 acquiring, 2 locked)
  int m_mode, m_run, m_loss, m_phase, m_cnt8, m_cnt2;
  bit m_valid, m_ill, m_seq;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else n_pass++;
  endtask

  task automatic model_reset();
    m_mode = 0; m_run = 0; m_loss = 0; m_phase = 0;
    m_cnt8 = 0; m_cnt2 = 0; m_valid = 0; m_ill = 0; m_seq = 0;
  endtask

  task automatic model_step(input int code, input bit en);
    int  idx;
    bit  succ;
    m_ill = 0;
    m_seq = 0;
    if (!en) return;
    idx = -1;
    for (int i = 0; i < 8; i++) if (jc[i] == code) idx = i;
    succ = (idx >= 0) && (idx == (m_phase + 1) % 8);
    if (idx < 0) m_ill = 1;
    if (m_mode == 0) begin
      if (idx >= 0) begin m_mode = 1; m_run = 0; end
    end else if (m_mode == 1) begin
      if (idx < 0) m_mode = 0;
      else if (succ) begin
        m_run++;
        if (m_run == 4) m_mode = 2;
      end else m_run = 0;
    end else begin
      if (succ) m_loss = 0;
      else begin
        if (idx >= 0) m_seq = 1;
        m_loss++;
        if (m_loss == 2) begin m_mode = 0; m_loss = 0; end
      end
    end
    if (idx >= 0) begin m_phase = idx; m_valid = 1; end
    else m_valid = 0;
    if (m_ill || m_seq) begin
      if (m_cnt8 < 255) m_cnt8++;
      if (m_cnt2 < 3) m_cnt2++;
    end
  endtask

  task automatic drive(input int code, input bit en);
    exp_t e;
    @(negedge clk);
    code_in = 4'(code);
    enable  = en;
    model_step(code, en);
    e.phase  = 3'(m_phase);
    e.valid  = m_valid;
    e.locked = (m_mode == 2);
    e.ill    = m_ill;
    e.seq    = m_seq;
    e.cnt8   = 8'(m_cnt8);
    e.cnt2   = 2'(m_cnt2);
    q.push_back(e);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_phase"}, 32'(phase), 32'd0);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
    chk({tag, "_locked"}, 32'(locked), 32'd0);
    chk({tag, "_ill"}, 32'(err_illegal), 32'd0);
    chk({tag, "_seq"}, 32'(err_seq), 32'd0);
    chk({tag, "_cnt"}, 32'(err_count), 32'd0);
    chk({tag, "_sat_cnt"}, 32'(s_err_count), 32'd0);
    chk({tag, "_sat_locked"}, 32'(s_locked), 32'd0);
  endtask

  // mid=1 asserts reset between clock edges while clk is high
  task automatic do_reset(input bit mid);
    if (mid) begin @(posedge clk); #3; end
    else @(negedge clk);
    async_reset_n = 1'b0;
    enable = 1'b0;
    model_reset();
    #1;
    chk_zero(mid ? "mid_reset" : "reset");
    @(negedge clk);
    async_reset_n = 1'b1;
  endtask

  // Monitor: compare every cycle's outputs against the oldest prediction
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      me = q.pop_front();
      chk("sb_phase", 32'(phase), 32'(me.phase));
      chk("sb_valid", 32'(valid), 32'(me.valid));
      chk("sb_locked", 32'(locked), 32'(me.locked));
      chk("sb_ill", 32'(err_illegal), 32'(me.ill));
      chk("sb_seq", 32'(err_seq), 32'(me.seq));
      chk("sb_cnt", 32'(err_count), 32'(me.cnt8));
      chk("sb_sat_cnt", 32'(s_err_count), 32'(me.cnt2));
      chk("sb_sat_locked", 32'(s_locked), 32'(me.locked));
      chk("sb_sat_phase", 32'(s_phase), 32'(me.phase));
      chk("sb_sat_valid", 32'(s_valid), 32'(me.valid));
      chk("sb_sat_ill", 32'(s_err_illegal), 32'(me.ill));
      chk("sb_sat_seq", 32'(s_err_seq), 32'(me.seq));
    end
  end

  initial begin
    int code;
    int r;
    model_reset();
    #2;
    chk_zero("por");
    @(negedge clk);
    async_reset_n = 1'b1;

    // Clean acquisition
    drive(4'b0000, 1); drive(4'b0001, 1); drive(4'b0011, 1); drive(4'b0111, 1);
    settle();
    chk("acq_not_yet_locked", 32'(locked), 32'd0);
    drive(4'b1111, 1);
    settle();
    chk("acq_locked", 32'(locked), 32'd1);
    chk("acq_phase", 32'(phase), 32'd4);
    chk("acq_cnt", 32'(err_count), 32'd0);

    // Wrap 7 -> 0 -> 1
    drive(4'b1110, 1); drive(4'b1100, 1); drive(4'b1000, 1);
    settle();
    chk("wrap_phase7", 32'(phase), 32'd7);
    drive(4'b0000, 1);
    settle();
    chk("wrap_phase0", 32'(phase), 32'd0);
    chk("wrap_no_seq", 32'(err_seq), 32'd0);
    drive(4'b0001, 1);
    settle();
    chk("wrap_locked", 32'(locked), 32'd1);
    chk("wrap_phase1", 32'(phase), 32'd1);
    chk("wrap_cnt", 32'(err_count), 32'd0);

    // Illegal glitch at phase 2
    drive(4'b0011, 1);
    drive(4'b0101, 1);
    settle();
    chk("glitch_ill", 32'(err_illegal), 32'd1);
    chk("glitch_valid", 32'(valid), 32'd0);
    chk("glitch_phase_held", 32'(phase), 32'd2);
    chk("glitch_still_locked", 32'(locked), 32'd1);
    drive(4'b1111, 1);
    settle();
    chk("glitch_seq", 32'(err_seq), 32'd1);
    chk("glitch_ill_cleared", 32'(err_illegal), 32'd0);
    chk("glitch_unlocked", 32'(locked), 32'd0);
    chk("glitch_cnt", 32'(err_count), 32'd2);

    // Stall: repeat phase 2 twice while locked
    do_reset(0);
    drive(4'b1100, 1); drive(4'b1000, 1); drive(4'b0000, 1); drive(4'b0001, 1);
    drive(4'b0011, 1);
    settle();
    chk("stall_pre_locked", 32'(locked), 32'd1);
    drive(4'b0011, 1);
    settle();
    chk("stall1_seq", 32'(err_seq), 32'd1);
    chk("stall1_locked", 32'(locked), 32'd1);
    drive(4'b0011, 1);
    settle();
    chk("stall2_seq", 32'(err_seq), 32'd1);
    chk("stall2_unlocked", 32'(locked), 32'd0);
    chk("stall2_cnt", 32'(err_count), 32'd2);

    // Saturation and enable hold
    for (int i = 0; i < 5; i++) drive(il[(i * 3) % 8], 1);
    settle();
    chk("sat_cnt2", 32'(s_err_count), 32'd3);
    chk("sat_cnt8", 32'(err_count), 32'd7);
    for (int i = 0; i < 3; i++) drive(int'($urandom_range(0, 15)), 0);
    settle();
    chk("hold_cnt2", 32'(s_err_count), 32'd3);
    chk("hold_ill", 32'(err_illegal), 32'd0);
    chk("hold_valid", 32'(valid), 32'd0);
    chk("hold_phase", 32'(phase), 32'd2);

    // Reset mid-operation, then reacquire
    drive(4'b0000, 1); drive(4'b0001, 1); drive(4'b0011, 1); drive(4'b0111, 1);
    drive(4'b1111, 1);
    settle();
    chk("pre_mid_locked", 32'(locked), 32'd1);
    do_reset(1);
    drive(4'b0111, 1); drive(4'b1111, 1); drive(4'b1110, 1); drive(4'b1100, 1);
    settle();
    chk("reacq_4th_unlocked", 32'(locked), 32'd0);
    drive(4'b1000, 1);
    settle();
    chk("reacq_locked", 32'(locked), 32'd1);
    chk("reacq_phase", 32'(phase), 32'd7);

    // Randomized traffic biased toward successors, stalls and glitches
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 65)      code = jc[(m_phase + 1) % 8];
      else if (r < 75) code = jc[m_phase];
      else if (r < 88) code = jc[$urandom_range(0, 7)];
      else             code = il[$urandom_range(0, 7)];
      drive(code, $urandom_range(0, 9) != 0);
      if (i == 300) do_reset($urandom_range(0, 1) == 1);
    end

    for (int i = 0; i < 20; i++) begin
      if (q.size() == 0) break;
      @(posedge clk);
      #2;
    end
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/johnson_decoder_checker.md
JOHNSON_DECODER_CHECKER -- requirements
Module: johnson_decoder_checker

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 4, meaning consecutive legal successor samples required to enter LOCKED (range 1..15).
REQ-002 SHALL have parameter LOSS_CNT, default 2, meaning consecutive sequence errors in LOCKED that force loss of lock (range 1..15).
REQ-003 SHALL have parameter ERR_W, default 8, meaning error counter width.
REQ-004 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port: async_reset_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port: enable  input  1  sample qualifier; 0 = hold all state, no checking.
REQ-007 SHALL have port: code_in  input  4  4-bit Johnson code from the falling-edge twisted-ring counter.
REQ-008 SHALL have port: phase  output  3  decoded phase index 0..7 of the last legal sample.
REQ-009 SHALL have port: valid  output  1  high when the last enabled sample was a legal code.
REQ-010 SHALL have port: locked  output  1  high in state LOCKED.
REQ-011 SHALL have port: err_illegal  output  1  one-cycle pulse: the last enabled sample was an illegal code.
REQ-012 SHALL have port: err_seq  output  1  one-cycle pulse: legal code, but not the successor of the previous sample, while LOCKED.
REQ-013 SHALL have port: err_count  output  ERR_W  saturating count of err_illegal plus err_seq events.

Function
REQ-014 SHALL decode the legal codes to phases as follows: 0000->0, 0001->1, 0011->2, 0111->3, 1111->4, 1110->5, 1100->6, 1000->7.
REQ-015 SHALL treat the other 8 codes as illegal: 0010, 0100, 0101, 0110, 1001, 1010, 1011, 1101.
REQ-016 SHALL treat phase p+1 mod 8 as the required successor of phase p; phase 0 follows phase 7 (wrap).
REQ-017 SHALL sample code_in only on rising clk edges with enable=1; the source changes on falling edges, giving half-cycle margin.
REQ-018 SHALL make all outputs registered, reflecting the sample taken at the same rising edge (1-cycle latency from sample edge to output).
REQ-019 SHALL keep all state and outputs unchanged when enable=0, except that err_illegal and err_seq SHALL be cleared.
REQ-020 SHALL implement FSM states UNLOCKED, ACQUIRE and LOCKED.
REQ-021 UNLOCKED: legal sample -> ACQUIRE with run counter=0, storing the phase; illegal sample -> stay.
REQ-022 ACQUIRE: successor sample -> run+1, entering LOCKED when run reaches LOCK_CNT; legal non-successor -> restart run at 0 from the new phase; illegal -> UNLOCKED.
REQ-023 LOCKED: successor sample -> clear the loss counter; non-successor legal or illegal -> loss+1, and on loss reaching LOSS_CNT -> UNLOCKED with loss=0.
REQ-024 SHALL set err_seq only in LOCKED; a repeated phase (stall) counts as a sequence error.
REQ-025 SHALL assert err_illegal for every illegal sample, in any state.
REQ-026 SHALL update phase only on legal samples and hold it on illegal samples; valid=0 on an illegal sample.
REQ-027 SHALL increment err_count by 1 per erroring sample, saturate at 2^ERR_W-1, and never wrap.
REQ-028 SHALL let the successor reference follow the latest legal sample even when that sample was an error, so that a single glitch costs one error.

Reset
REQ-029 SHALL, when async_reset_n=0, immediately force: state=UNLOCKED, run=0, loss=0, phase=0, valid=0, locked=0, err_illegal=0, err_seq=0, err_count=0.
REQ-030 SHALL allow reset assertion mid-sequence to override all activity; the first enabled sample after release SHALL be treated as from UNLOCKED.
REQ-031 SHALL have no synchronous clear; err_count is cleared only by reset.

Verification
REQ-032 SHALL cover clean acquisition: reset, then enable=1 with the sequence 0000, 0001, 0011, 0111, 1111 -> locked=1 after the 5th sample edge, phase=4, err_count=0.
REQ-033 SHALL cover wrap: while LOCKED, 1000 -> 0000 -> 0001 -> locked stays 1, phase 7 -> 0 -> 1, no error pulses.
REQ-034 SHALL cover an illegal glitch: while LOCKED at phase 2, inject 0101 then resume 1111 -> err_illegal pulses once, valid=0 for that cycle, a second error is counted on 1111 (non-successor of 0011), loss=2 -> UNLOCKED, err_count=2.
REQ-035 SHALL cover a stall: while LOCKED, repeat 0011 twice -> err_seq pulses on each repeat, UNLOCKED after the 2nd repeat, err_count=2.
REQ-036 SHALL cover saturation and enable: with ERR_W=2, feed 5 illegal codes -> err_count=3; then enable=0 for 3 cycles with arbitrary code_in -> all state held, no error pulses.
REQ-037 SHALL cover reset mid-operation: assert async_reset_n=0 between clock edges while LOCKED -> all outputs 0 without waiting for a clock edge; after release, the sequence 0111, 1111, 1110, 1100, 1000 -> locked=1 at the 5th sample.
